// File: rtl/bsg_dfi_cmd_sched.sv
// rtl/bsg_dfi_cmd_sched.sv - closed-page DFI command scheduler, one access per ACT/PRE pair
//
// Arbitrates between one write and one read request port (round-robin on ties),
// then issues ACT, WR/RD, data-beat enables and PRE on a registered DFI command bus.
// Ports:
//   clk_i, reset_i                      : DFI 1x clock, synchronous active-high reset
//   wr_v_i/wr_bank_i/wr_row_i/wr_col_i  : write request, accepted with wr_ready_o
//   rd_v_i/rd_bank_i/rd_row_i/rd_col_i  : read request, accepted with rd_ready_o
//   dfi_bank_o/dfi_address_o            : DFI bank and address (0 on NOP)
//   dfi_cs_n_o/ras_n/cas_n/we_n         : DFI command, active low
//   dfi_wrdata_en_o/dfi_rddata_en_o     : data beat enables
//   busy_o                              : scheduler not idle
module bsg_dfi_cmd_sched #(
  parameter int trcd_p      = 3,
  parameter int trp_p       = 3,
  parameter int twr_p       = 4,
  parameter int wrlat_p     = 2,
  parameter int rdlat_p     = 3,
  parameter int burst_len_p = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_v_i,
  input  logic [2:0]  wr_bank_i,
  input  logic [15:0] wr_row_i,
  input  logic [15:0] wr_col_i,
  output logic        wr_ready_o,
  input  logic        rd_v_i,
  input  logic [2:0]  rd_bank_i,
  input  logic [15:0] rd_row_i,
  input  logic [15:0] rd_col_i,
  output logic        rd_ready_o,
  output logic [2:0]  dfi_bank_o,
  output logic [15:0] dfi_address_o,
  output logic        dfi_cs_n_o,
  output logic        dfi_ras_n_o,
  output logic        dfi_cas_n_o,
  output logic        dfi_we_n_o,
  output logic        dfi_wrdata_en_o,
  output logic        dfi_rddata_en_o,
  output logic        busy_o
);

  // Cycles from the CAS command to the PRE command for each direction.
  localparam int wr_span_lp  = wrlat_p + burst_len_p + twr_p;
  localparam int rd_span_lp  = rdlat_p + burst_len_p;
  localparam int span_max_lp = (wr_span_lp > rd_span_lp) ? wr_span_lp : rd_span_lp;
  localparam int tim_max_lp  = (trcd_p > trp_p) ? trcd_p : trp_p;
  localparam int cnt_max_lp  = (span_max_lp > tim_max_lp) ? span_max_lp : tim_max_lp;
  localparam int cnt_w_lp    = $clog2(cnt_max_lp + 1);

  typedef logic [cnt_w_lp-1:0] cnt_t;

  // Terminal counts: each timed state exits when the counter hits its "last" value.
  localparam cnt_t trcd_last_lp = cnt_t'((trcd_p > 1) ? trcd_p - 2 : 0);
  localparam cnt_t trp_last_lp  = cnt_t'(trp_p - 1);
  localparam cnt_t wr_last_lp   = cnt_t'(wr_span_lp - 1);
  localparam cnt_t rd_last_lp   = cnt_t'(rd_span_lp - 1);
  localparam cnt_t wr_beg_lp    = cnt_t'(wrlat_p);
  localparam cnt_t wr_end_lp    = cnt_t'(wrlat_p + burst_len_p);
  localparam cnt_t rd_beg_lp    = cnt_t'(rdlat_p);
  localparam cnt_t rd_end_lp    = cnt_t'(rdlat_p + burst_len_p);

  localparam logic [3:0] cmd_nop = 4'b1111;
  localparam logic [3:0] cmd_act = 4'b0011;
  localparam logic [3:0] cmd_wr  = 4'b0100;
  localparam logic [3:0] cmd_rd  = 4'b0101;
  localparam logic [3:0] cmd_pre = 4'b0010;

  typedef enum logic [2:0] {
    s_idle, s_act, s_trcd, s_cas, s_data, s_pre, s_trp
  } state_e;

  state_e      state_r, state_n;
  cnt_t        cnt_r, cnt_n;
  logic        last_wr_r;
  logic        is_wr_r;
  logic [2:0]  bank_r;
  logic [15:0] col_r;

  logic        idle, grant_wr, grant_rd, hs;
  logic [2:0]  hs_bank;
  logic [15:0] hs_row, hs_col;
  logic [3:0]  cmd_n;
  logic [2:0]  bank_n;
  logic [15:0] addr_n;
  logic        wren_n, rden_n, in_win;
  cnt_t        data_last, beat_beg, beat_end;

  // Arbitration: the pointer remembers the last grant, so a tie goes to the other side.
  assign idle       = (state_r == s_idle);
  assign grant_wr   = wr_v_i & (~rd_v_i | ~last_wr_r);
  assign grant_rd   = rd_v_i & (~wr_v_i | last_wr_r);
  assign wr_ready_o = idle & ~reset_i & grant_wr;
  assign rd_ready_o = idle & ~reset_i & grant_rd;
  assign hs         = wr_ready_o | rd_ready_o;
  assign hs_bank    = grant_wr ? wr_bank_i : rd_bank_i;
  assign hs_row     = grant_wr ? wr_row_i  : rd_row_i;
  assign hs_col     = grant_wr ? wr_col_i  : rd_col_i;
  assign busy_o     = ~idle;

  assign data_last = is_wr_r ? wr_last_lp : rd_last_lp;
  assign beat_beg  = is_wr_r ? wr_beg_lp  : rd_beg_lp;
  assign beat_end  = is_wr_r ? wr_end_lp  : rd_end_lp;

  // Next-state logic. In DATA the counter holds cycles elapsed since CAS.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + cnt_t'(1);
    case (state_r)
      s_idle: begin
        cnt_n = '0;
        if (hs) state_n = s_act;
      end
      s_act: begin
        cnt_n   = '0;
        state_n = (trcd_p > 1) ? s_trcd : s_cas;
      end
      s_trcd: begin
        if (cnt_r == trcd_last_lp) begin
          state_n = s_cas;
          cnt_n   = '0;
        end
      end
      s_cas: begin
        state_n = s_data;
        cnt_n   = cnt_t'(1);
      end
      s_data: begin
        if (cnt_r == data_last) begin
          state_n = s_pre;
          cnt_n   = '0;
        end
      end
      s_pre: begin
        state_n = s_trp;
        cnt_n   = '0;
      end
      s_trp: begin
        if (cnt_r == trp_last_lp) begin
          state_n = s_idle;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = s_idle;
        cnt_n   = '0;
      end
    endcase
  end

  // DFI outputs are a registered decode of the next state, so the bus always
  // shows the command of the state currently held in state_r. ACT is only ever
  // entered from IDLE, so its row comes straight from the handshaking port and
  // the row never has to be held.
  always_comb begin
    cmd_n  = cmd_nop;
    bank_n = '0;
    addr_n = '0;
    case (state_n)
      s_act: begin
        cmd_n  = cmd_act;
        bank_n = hs_bank;
        addr_n = hs_row;
      end
      s_cas: begin
        cmd_n  = is_wr_r ? cmd_wr : cmd_rd;
        bank_n = bank_r;
        addr_n = col_r;
      end
      s_pre: begin
        cmd_n  = cmd_pre;
        bank_n = bank_r;
      end
      default: ;
    endcase
    in_win = (cnt_n >= beat_beg) && (cnt_n < beat_end);
    wren_n = (state_n == s_data) && is_wr_r && in_win;
    rden_n = (state_n == s_data) && !is_wr_r && in_win;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r         <= s_idle;
      cnt_r           <= '0;
      last_wr_r       <= 1'b1;
      is_wr_r         <= 1'b0;
      bank_r          <= '0;
      col_r           <= '0;
      {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= cmd_nop;
      dfi_bank_o      <= '0;
      dfi_address_o   <= '0;
      dfi_wrdata_en_o <= 1'b0;
      dfi_rddata_en_o <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (hs) begin
        last_wr_r <= grant_wr;
        is_wr_r   <= grant_wr;
        bank_r    <= hs_bank;
        col_r     <= hs_col;
      end
      {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= cmd_n;
      dfi_bank_o      <= bank_n;
      dfi_address_o   <= addr_n;
      dfi_wrdata_en_o <= wren_n;
      dfi_rddata_en_o <= rden_n;
    end
  end

endmodule

// File: tb/tb_bsg_dfi_cmd_sched.sv
// tb/tb_bsg_dfi_cmd_sched.sv - self-checking bench for bsg_dfi_cmd_sched
module tb_bsg_dfi_cmd_sched;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [2:0]  bank;
    logic [15:0] addr;
    logic        wren;
    logic        rden;
    logic        busy;
  } obs_t;

  typedef struct {
    int trcd; int trp; int twr; int wrlat; int rdlat; int bl;
  } prm_t;

  typedef struct {
    logic        rst;
    logic        wr_v;
    logic        rd_v;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [15:0] col;
    logic        exp_wrr;
    logic        exp_rdr;
    obs_t        exp;
  } vec_t;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam obs_t NOP_O = '{cmd: 4'hf, bank: 3'd0, addr: 16'd0, wren: 1'b0, rden: 1'b0, busy: 1'b0};
  localparam int NV = 51;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_v, rd_v;
  logic [2:0]  wr_bank, rd_bank;
  logic [15:0] wr_row, wr_col, rd_row, rd_col;

  logic        a_wrr, a_rdr, a_cs, a_ras, a_cas, a_we, a_wren, a_rden, a_busy;
  logic [2:0]  a_bank;
  logic [15:0] a_addr;
  logic        b_wrr, b_rdr, b_cs, b_ras, b_cas, b_we, b_wren, b_rden, b_busy;
  logic [2:0]  b_bank;
  logic [15:0] b_addr;

  bit   use_min = 1'b0;
  obs_t obs_a, obs_b, obs;
  logic [1:0] rdy;
  assign obs_a = {a_cs, a_ras, a_cas, a_we, a_bank, a_addr, a_wren, a_rden, a_busy};
  assign obs_b = {b_cs, b_ras, b_cas, b_we, b_bank, b_addr, b_wren, b_rden, b_busy};
  assign obs   = use_min ? obs_b : obs_a;
  assign rdy   = use_min ? {b_wrr, b_rdr} : {a_wrr, a_rdr};

  always #5 clk = ~clk;

  bsg_dfi_cmd_sched dut_a (
    .clk_i(clk), .reset_i(reset),
    .wr_v_i(wr_v), .wr_bank_i(wr_bank), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_ready_o(a_wrr),
    .rd_v_i(rd_v), .rd_bank_i(rd_bank), .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_ready_o(a_rdr),
    .dfi_bank_o(a_bank), .dfi_address_o(a_addr), .dfi_cs_n_o(a_cs), .dfi_ras_n_o(a_ras),
    .dfi_cas_n_o(a_cas), .dfi_we_n_o(a_we), .dfi_wrdata_en_o(a_wren), .dfi_rddata_en_o(a_rden),
    .busy_o(a_busy)
  );

  bsg_dfi_cmd_sched #(
    .trcd_p(1), .trp_p(1), .twr_p(1), .wrlat_p(1), .rdlat_p(1), .burst_len_p(1)
  ) dut_b (
    .clk_i(clk), .reset_i(reset),
    .wr_v_i(wr_v), .wr_bank_i(wr_bank), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_ready_o(b_wrr),
    .rd_v_i(rd_v), .rd_bank_i(rd_bank), .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_ready_o(b_rdr),
    .dfi_bank_o(b_bank), .dfi_address_o(b_addr), .dfi_cs_n_o(b_cs), .dfi_ras_n_o(b_ras),
    .dfi_cas_n_o(b_cas), .dfi_we_n_o(b_we), .dfi_wrdata_en_o(b_wren), .dfi_rddata_en_o(b_rden),
    .busy_o(b_busy)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  prm_t prm;
  vec_t tbl [NV];

  bit          m_act, m_wr, m_last_wr;
  int          m_t0;
  logic [2:0]  m_bank;
  logic [15:0] m_row, m_col;
  bit          dut_grants[$];

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected bus contents k cycles after a handshake, straight from the timing rules.
  function automatic obs_t model_out(prm_t p, int k, bit wr, logic [2:0] bank,
                                     logic [15:0] row, logic [15:0] col);
    obs_t o;
    int c, d0, pre;
    o   = NOP_O;
    c   = 1 + p.trcd;
    d0  = c + (wr ? p.wrlat : p.rdlat);
    pre = d0 + p.bl + (wr ? p.twr : 0);
    o.busy = (k >= 1) && (k <= pre + p.trp);
    if (k == 1) begin
      o.cmd = C_ACT; o.bank = bank; o.addr = row;
    end else if (k == c) begin
      o.cmd = wr ? C_WR : C_RD; o.bank = bank; o.addr = col;
    end else if (k == pre) begin
      o.cmd = C_PRE; o.bank = bank;
    end
    if (k >= d0 && k < d0 + p.bl) begin
      if (wr) o.wren = 1'b1;
      else    o.rden = 1'b1;
    end
    return o;
  endfunction

  task automatic model_obs();
    obs_t e;
    e = NOP_O;
    if (m_act) begin
      e = model_out(prm, cyc - m_t0, m_wr, m_bank, m_row, m_col);
      if (!e.busy) m_act = 1'b0;
    end
    check("model obs", 32'(obs), 32'(e));
  endtask

  task automatic model_ready();
    bit gw, gr;
    gw = !m_act && wr_v && (!rd_v || !m_last_wr);
    gr = !m_act && rd_v && (!wr_v || m_last_wr);
    check("model rdy", 32'(rdy), 32'({gw, gr}));
    if (rdy[1] && wr_v)      dut_grants.push_back(1'b1);
    else if (rdy[0] && rd_v) dut_grants.push_back(1'b0);
    if (gw || gr) begin
      m_act = 1'b1; m_t0 = cyc; m_wr = gw; m_last_wr = gw;
      m_bank = gw ? wr_bank : rd_bank;
      m_row  = gw ? wr_row  : rd_row;
      m_col  = gw ? wr_col  : rd_col;
    end
  endtask

  task automatic run_model(int n, bit rnd);
    repeat (n) begin
      model_obs();
      if (rnd) begin
        wr_v = 1'($urandom_range(0, 1)); rd_v = 1'($urandom_range(0, 1));
        wr_bank = 3'($urandom); wr_row = 16'($urandom); wr_col = 16'($urandom);
        rd_bank = 3'($urandom); rd_row = 16'($urandom); rd_col = 16'($urandom);
      end
      #1;
      model_ready();
      next_cycle();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_v = 1'b0; rd_v = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();
    m_act = 1'b0; m_last_wr = 1'b1;
  endtask

  task automatic set_in(int lo, int hi, bit wv, bit rv, logic [2:0] b, logic [15:0] r, logic [15:0] c);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].wr_v = wv; tbl[i].rd_v = rv; tbl[i].bank = b; tbl[i].row = r; tbl[i].col = c;
    end
  endtask

  task automatic set_cmd(int i, logic [3:0] c, logic [2:0] b, logic [15:0] a);
    tbl[i].exp.cmd = c; tbl[i].exp.bank = b; tbl[i].exp.addr = a;
  endtask

  task automatic set_busy(int lo, int hi);
    for (int i = lo; i <= hi; i++) tbl[i].exp.busy = 1'b1;
  endtask

  initial begin
    int pre_cyc;
    // Directed vectors: single write (rows 0-18), single read (19-34), reset mid-write (35-50).
    for (int i = 0; i < NV; i++)
      tbl[i] = '{rst: 1'b0, wr_v: 1'b0, rd_v: 1'b0, bank: 3'd0, row: 16'd0, col: 16'd0,
                 exp_wrr: 1'b0, exp_rdr: 1'b0, exp: NOP_O};
    set_in(0, 0, 1, 0, 3'd5, 16'h1234, 16'h0abc);
    set_in(1, 16, 1, 0, 3'd2, 16'h5555, 16'h7777);
    tbl[0].exp_wrr = 1'b1; tbl[16].exp_wrr = 1'b1;
    set_busy(1, 15);
    set_cmd(1, C_ACT, 3'd5, 16'h1234);
    set_cmd(4, C_WR, 3'd5, 16'h0abc);
    tbl[6].exp.wren = 1'b1; tbl[7].exp.wren = 1'b1;
    set_cmd(12, C_PRE, 3'd5, 16'h0000);
    tbl[17].rst = 1'b1; set_busy(17, 17); set_cmd(17, C_ACT, 3'd2, 16'h5555);

    set_in(19, 32, 0, 1, 3'd3, 16'h0f0f, 16'h0040);
    tbl[19].exp_rdr = 1'b1; tbl[32].exp_rdr = 1'b1;
    set_busy(20, 31);
    set_cmd(20, C_ACT, 3'd3, 16'h0f0f);
    set_cmd(23, C_RD, 3'd3, 16'h0040);
    tbl[26].exp.rden = 1'b1; tbl[27].exp.rden = 1'b1;
    set_cmd(28, C_PRE, 3'd3, 16'h0000);
    tbl[33].rst = 1'b1; set_busy(33, 33); set_cmd(33, C_ACT, 3'd3, 16'h0f0f);

    set_in(35, 35, 1, 0, 3'd7, 16'h8001, 16'h00ff);
    tbl[35].exp_wrr = 1'b1;
    set_busy(36, 40);
    set_cmd(36, C_ACT, 3'd7, 16'h8001);
    set_cmd(39, C_WR, 3'd7, 16'h00ff);
    tbl[40].rst = 1'b1;
    set_in(41, 41, 1, 0, 3'd1, 16'h0246, 16'h0135);
    tbl[41].exp_wrr = 1'b1;
    set_in(42, 48, 1, 0, 3'd6, 16'hffff, 16'hffff);
    set_busy(42, 49);
    set_cmd(42, C_ACT, 3'd1, 16'h0246);
    set_cmd(45, C_WR, 3'd1, 16'h0135);
    tbl[47].exp.wren = 1'b1; tbl[48].exp.wren = 1'b1;
    tbl[49].rst = 1'b1;

    reset = 1'b1; wr_v = 1'b0; rd_v = 1'b0;
    wr_bank = '0; wr_row = '0; wr_col = '0; rd_bank = '0; rd_row = '0; rd_col = '0;
    prm = '{trcd: 3, trp: 3, twr: 4, wrlat: 2, rdlat: 3, bl: 2};
    repeat (3) next_cycle();
    check("reset obs", 32'(obs), 32'(NOP_O));
    check("reset obs min", 32'(obs_b), 32'(NOP_O));
    wr_v = 1'b1; rd_v = 1'b1;
    #1;
    check("reset rdy", 32'(rdy), 32'd0);
    wr_v = 1'b0; rd_v = 1'b0; reset = 1'b0;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d obs", i), 32'(obs), 32'(tbl[i].exp));
      reset = tbl[i].rst; wr_v = tbl[i].wr_v; rd_v = tbl[i].rd_v;
      wr_bank = tbl[i].bank; wr_row = tbl[i].row; wr_col = tbl[i].col;
      rd_bank = tbl[i].bank; rd_row = tbl[i].row; rd_col = tbl[i].col;
      #1;
      check($sformatf("vec%0d rdy", i), 32'(rdy), 32'({tbl[i].exp_wrr, tbl[i].exp_rdr}));
      next_cycle();
    end

    // Both requesters held valid: grants must alternate read, write, read, write.
    do_reset();
    dut_grants.delete();
    wr_bank = 3'd1; wr_row = 16'h1111; wr_col = 16'h1a1a;
    rd_bank = 3'd6; rd_row = 16'h6666; rd_col = 16'h6b6b;
    wr_v = 1'b1; rd_v = 1'b1;
    run_model(70, 1'b0);
    check("rr count", 32'(dut_grants.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < dut_grants.size()) check("rr grant", 32'(dut_grants[i]), 32'(i % 2));

    do_reset();
    run_model(500, 1'b1);

    // Minimum timing parameters: back-to-back reads.
    use_min = 1'b1;
    prm = '{trcd: 1, trp: 1, twr: 1, wrlat: 1, rdlat: 1, bl: 1};
    do_reset();
    rd_v = 1'b1; wr_v = 1'b0;
    rd_bank = 3'd4; rd_row = 16'h0c0c; rd_col = 16'h0d0d;
    pre_cyc = -1;
    for (int i = 0; i < 24; i++) begin
      model_obs();
      if (obs.cmd == C_PRE) pre_cyc = cyc;
      if (obs.cmd == C_ACT && pre_cyc >= 0) begin
        check("act gap", 32'(cyc - pre_cyc), 32'd3);
        pre_cyc = -1;
      end
      #1;
      model_ready();
      next_cycle();
    end

    do_reset();
    run_model(300, 1'b1);

    wr_v = 1'b0; rd_v = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
